// File: rtl/aes_128_sched.sv
// rtl/aes_128_sched.sv - issue scheduler and in-order result FIFO around a fixed-latency aes_128 core
module aes_128_sched #(
    parameter int LATENCY = 21,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [127:0]                  req_state,
    input  logic [127:0]                  req_key,
    input  logic [TAG_W-1:0]              req_tag,
    output logic [127:0]                  aes_state,
    output logic [127:0]                  aes_key,
    input  logic [127:0]                  aes_out,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [127:0]                  rsp_data,
    output logic [TAG_W-1:0]              rsp_tag,
    output logic [$clog2(LATENCY+2)-1:0]  inflight,
    output logic                          busy
);
    localparam int IW = $clog2(LATENCY + 2);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = ((IW > CW) ? IW : CW) + 1;

    logic [127:0]     aes_state_q, aes_state_d;
    logic [127:0]     aes_key_q, aes_key_d;
    logic [LATENCY:0] vld_q, vld_d;
    logic [TAG_W-1:0] tag_q [0:LATENCY];
    logic [TAG_W-1:0] tag_d [0:LATENCY];
    logic [IW-1:0]    inflight_q, inflight_d;
    logic [127:0]     mem_data_q [0:DEPTH-1];
    logic [127:0]     mem_data_d [0:DEPTH-1];
    logic [TAG_W-1:0] mem_tag_q [0:DEPTH-1];
    logic [TAG_W-1:0] mem_tag_d [0:DEPTH-1];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    occupancy;
    logic             issue;
    logic             push;
    logic             pop;

    // Reserving a FIFO slot per in-flight request means a capture never finds the FIFO full.
    assign occupancy = SW'(inflight_q) + SW'(count_q);
    assign req_ready = !rst && (occupancy < SW'(DEPTH));
    assign issue     = req_valid && req_ready;
    assign push      = vld_q[LATENCY];
    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = mem_data_q[rd_ptr_q];
    assign rsp_tag   = mem_tag_q[rd_ptr_q];
    assign aes_state = aes_state_q;
    assign aes_key   = aes_key_q;
    assign inflight  = inflight_q;
    assign busy      = (inflight_q != '0) || (count_q != '0);

    always_comb begin
        aes_state_d = issue ? req_state : aes_state_q;
        aes_key_d   = issue ? req_key : aes_key_q;
        vld_d       = {vld_q[LATENCY-1:0], issue};
        tag_d[0]    = req_tag;
        for (int i = 1; i <= LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        inflight_d = inflight_q;
        case ({issue, push})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase

        mem_data_d = mem_data_q;
        mem_tag_d  = mem_tag_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            mem_data_d[wr_ptr_q] = aes_out;
            mem_tag_d[wr_ptr_q]  = tag_q[LATENCY];
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aes_state_q <= '0;
            aes_key_q   <= '0;
            vld_q       <= '0;
            inflight_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                tag_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_tag_q[i]  <= '0;
            end
        end else begin
            aes_state_q <= aes_state_d;
            aes_key_q   <= aes_key_d;
            vld_q       <= vld_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tag_q       <= tag_d;
            mem_data_q  <= mem_data_d;
            mem_tag_q   <= mem_tag_d;
        end
    end
endmodule
